// File: rtl/arbitro_pkg.sv
// Shared definitions for the 4-source FIFO arbiter: source count, FSM encodings
// and the position of the destination field inside a FIFO word.
package arbitro_pkg;

  localparam int N_SRC  = 4;
  localparam int IDX_W  = 2;
  localparam int DEST_W = 2;

  typedef enum logic [1:0] {
    SETUP  = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  // The destination index lives in the top DEST_W bits of each word.
  function automatic int dest_msb(input int width);
    return width - 1;
  endfunction

  function automatic int dest_lsb(input int width);
    return width - DEST_W;
  endfunction

endpackage

// File: rtl/arbitro_rr_pick.sv
// Combinational selector: first set request bit found scanning upward from a
// start pointer (wrapping), returned as one-hot grant plus binary index.
module arb_pick
  import arbitro_pkg::*;
(
  input  logic [N_SRC-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_SRC-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = ptr_i + IDX_W'(k);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
        gnt_o = N_SRC'(1) << cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/arbitro_rr.sv
// Arbiter moving head words from four show-ahead source FIFOs to four destination
// FIFOs. Define ARB_RR_EN for round-robin selection; otherwise fixed priority.
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SRC-1:0]       emptyFIFO,
  input  logic [N_SRC*WIDTH-1:0] data_in,
  input  logic [N_SRC-1:0]       almost_fullFIFO,
  output logic [N_SRC-1:0]       pop,
  output logic [N_SRC-1:0]       push,
  output logic [WIDTH-1:0]       data_out,
  output logic [IDX_W-1:0]       grant_id,
  output logic                   idle
);

  localparam int DMSB = dest_msb(WIDTH);
  localparam int DLSB = dest_lsb(WIDTH);

  state_e            state_q;
  logic [N_SRC-1:0]  pop_q;
  logic [N_SRC-1:0]  push_q;
  logic [N_SRC-1:0]  push_d;
  logic [WIDTH-1:0]  data_q;
  logic [WIDTH-1:0]  data_d;
  logic [IDX_W-1:0]  grant_q;
  logic              idle_q;

  logic [WIDTH-1:0]  head [N_SRC];
  logic [DEST_W-1:0] dest [N_SRC];
  logic [N_SRC-1:0]  req;
  logic [IDX_W-1:0]  ptr;
  logic [N_SRC-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  // A source whose pop is registered this cycle still shows the old head, so it
  // must sit out one cycle or the same word would be taken twice.
  always_comb begin
    req = '0;
    for (int i = 0; i < N_SRC; i++) begin
      head[i] = data_in[i*WIDTH +: WIDTH];
      dest[i] = head[i][DMSB:DLSB];
      req[i]  = !emptyFIFO[i] && !almost_fullFIFO[dest[i]] && !pop_q[i];
    end
  end

  arb_pick u_pick (
    .req_i (req),
    .ptr_i (ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    data_d = head[pick_idx];
    push_d = N_SRC'(1) << dest[pick_idx];
  end

`ifdef ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;

  assign ptr = ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (state_q != SETUP && pick_any) begin
      ptr_q <= pick_idx + IDX_W'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SETUP;
      pop_q   <= '0;
      push_q  <= '0;
      data_q  <= '0;
      grant_q <= '0;
      idle_q  <= 1'b0;
    end else begin
      case (state_q)
        SETUP: begin
          state_q <= IDLE;
          idle_q  <= 1'b1;
          pop_q   <= '0;
          push_q  <= '0;
        end
        default: begin
          if (pick_any) begin
            state_q <= ACTIVE;
            idle_q  <= 1'b0;
            pop_q   <= pick_gnt;
            push_q  <= push_d;
            data_q  <= data_d;
            grant_q <= pick_idx;
          end else begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
            pop_q   <= '0;
            push_q  <= '0;
          end
        end
      endcase
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign data_out = data_q;
  assign grant_id = grant_q;
  assign idle     = idle_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: a reference model queues the expected registered
// outputs for each cycle, which are popped and compared after the clock edge.
module tb_arbitro_rr;

  localparam int W = 6;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     emptyFIFO;
  logic [3:0]     almost_fullFIFO;
  logic [4*W-1:0] data_in;
  logic [3:0]     pop;
  logic [3:0]     push;
  logic [W-1:0]   data_out;
  logic [1:0]     grant_id;
  logic           idle;

  arbitro_rr #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .emptyFIFO       (emptyFIFO),
    .data_in         (data_in),
    .almost_fullFIFO (almost_fullFIFO),
    .pop             (pop),
    .push            (push),
    .data_out        (data_out),
    .grant_id        (grant_id),
    .idle            (idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   pop;
    logic [3:0]   push;
    logic [W-1:0] data;
    logic [1:0]   gid;
    logic         idle;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   m_state;
  int   m_ptr;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ptr   = 0;
    m       = '0;
  endtask

  task automatic set_head(input int i, input logic [W-1:0] w);
    data_in[i*W +: W] = w;
  endtask

  // Reference behaviour for the upcoming edge, computed from the inputs now applied.
  task automatic predict();
    int         sel;
    int         i;
    logic [1:0] d;
    if (m_state == 0) begin
      m_state = 1;
      m.idle  = 1'b1;
      m.pop   = '0;
      m.push  = '0;
    end else begin
      sel = -1;
      for (int k = 0; k < 4; k++) begin
        i = RR ? (m_ptr + k) % 4 : k;
        d = data_in[i*W + W-2 +: 2];
        if (sel < 0 && !emptyFIFO[i] && !almost_fullFIFO[d] && !m.pop[i]) sel = i;
      end
      if (sel >= 0) begin
        d       = data_in[sel*W + W-2 +: 2];
        m_state = 2;
        m.idle  = 1'b0;
        m.pop   = 4'(1 << sel);
        m.push  = 4'(1 << d);
        m.data  = data_in[sel*W +: W];
        m.gid   = 2'(sel);
        m_ptr   = (sel + 1) % 4;
      end else begin
        m_state = 1;
        m.idle  = 1'b1;
        m.pop   = '0;
        m.push  = '0;
      end
    end
    sb.push_back(m);
  endtask

  task automatic step(input string tag);
    exp_t e;
    predict();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp({tag, ".pop"},      32'(pop),      32'(e.pop));
    cmp({tag, ".push"},     32'(push),     32'(e.push));
    cmp({tag, ".data_out"}, 32'(data_out), 32'(e.data));
    cmp({tag, ".grant_id"}, 32'(grant_id), 32'(e.gid));
    cmp({tag, ".idle"},     32'(idle),     32'(e.idle));
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, ".pop"},      32'(pop),      32'd0);
    cmp({tag, ".push"},     32'(push),     32'd0);
    cmp({tag, ".data_out"}, 32'(data_out), 32'd0);
    cmp({tag, ".grant_id"}, 32'(grant_id), 32'd0);
    cmp({tag, ".idle"},     32'(idle),     32'd0);
  endtask

  initial begin
    logic [1:0] gseq [5];
    logic       found;

    reset           = 1'b0;
    emptyFIFO       = 4'hF;
    almost_fullFIFO = 4'h0;
    data_in         = '0;
    model_reset();

    // Reset held for three cycles: everything zero, not idle.
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("reset");
    end
    reset = 1'b1;
    #1;
    cmp("setup.idle_before_edge", 32'(idle), 32'd0);
    step("setup");
    cmp("idle_after_setup", 32'(idle), 32'd1);
    step("idle_empty");

    // Only source 2 non-empty, head 01_0101: served every second cycle.
    emptyFIFO = 4'b1011;
    set_head(2, 6'b010101);
    for (int k = 0; k < 6; k++) begin
      step("src2");
      cmp("src2.pop_pattern", 32'(pop), (k % 2 == 0) ? 32'b0100 : 32'b0000);
      cmp("src2.push_pattern", 32'(push), (k % 2 == 0) ? 32'b0010 : 32'b0000);
      cmp("src2.data_out", 32'(data_out), 32'b010101);
    end

    // Fresh reset, then all four sources busy with distinct destinations.
    #2 reset = 1'b0;
    model_reset();
    #1 check_zero("rst_pulse");
    #1 reset = 1'b1;
    emptyFIFO = 4'b0000;
    for (int i = 0; i < 4; i++) set_head(i, 6'((i << 4) | (i + 5)));
    step("setup2");
    cmp("setup2.no_pop", 32'(pop), 32'd0);
    gseq = RR ? '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0} : '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    for (int k = 0; k < 5; k++) begin
      step("all4");
      cmp("all4.grant_seq", 32'(grant_id), 32'(gseq[k]));
      cmp("all4.push_dest", 32'(push), 32'(4'(1 << gseq[k])));
    end

    // Sources 0..3 target destinations 3..0; block destinations one by one.
    for (int i = 0; i < 4; i++) set_head(i, 6'(((3 - i) << 4) | (i + 9)));
    step("dst_open0");
    step("dst_open1");
    almost_fullFIFO = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      step("af1000");
      cmp("af1000.src0_blocked", 32'(pop[0]), 32'd0);
    end
    almost_fullFIFO = 4'b1100;
    for (int k = 0; k < 3; k++) begin
      step("af1100");
      cmp("af1100.src01_blocked", 32'(pop & 4'b0011), 32'd0);
    end
    almost_fullFIFO = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      step("af1110");
      cmp("af1110.only_dest0", 32'(push & 4'b1110), 32'd0);
    end

    // Asynchronous reset while a push to destination 0 is in flight.
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      step("seek_push0");
      if (push === 4'b0001) found = 1'b1;
    end
    cmp("push0_seen", 32'(found), 32'd1);
    if (found) begin
      #2 reset = 1'b0;
      model_reset();
      #1 check_zero("async_reset");
      #1 reset = 1'b1;
    end
    step("setup3");
    step("after_reset0");
    step("after_reset1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arbitro_rr.md
ARBITRO_RR -- requirements
Module: arbitro_rr

Interface
REQ-001 Parameter WIDTH, default 6: FIFO word width; bits [WIDTH-1:WIDTH-2] carry the destination index.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 emptyFIFO  input  4  per-source FIFO empty flag; bit i high means source i holds no word.
REQ-005 data_in  input  4*WIDTH  show-ahead head words; source i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-006 almost_fullFIFO  input  4  per-destination FIFO almost-full flag; bit d high blocks pushes to d.
REQ-007 pop  output  4  one-hot or zero; pop[i] consumes the head of source i.
REQ-008 push  output  4  one-hot or zero; push[d] writes data_out into destination d.
REQ-009 data_out  output  WIDTH  word being pushed; meaningful only while push is nonzero.
REQ-010 grant_id  output  2  index of the source popped this cycle; holds its last value otherwise.
REQ-011 idle  output  1  high when the FSM is in IDLE.

Function
REQ-012 FSM states SETUP, IDLE, ACTIVE; encodings 2'd0, 2'd1, 2'd2.
REQ-013 SETUP lasts exactly one cycle after reset deassertion, then goes to IDLE; no pop/push in SETUP.
REQ-014 A source i is eligible when emptyFIFO[i]=0, almost_fullFIFO[dest(i)]=0, and i was not popped in the current cycle.
REQ-015 IDLE -> ACTIVE and ACTIVE -> ACTIVE on any edge with at least one eligible source; otherwise next state is IDLE.
REQ-016 On an edge with an eligible source, the selected source s registers pop=1<<s, push=1<<dest(s), data_out=head(s), grant_id=s; all outputs are registered (one-cycle latency from flag sampling).
REQ-017 On an edge with no eligible source, pop and push register 0; data_out and grant_id hold.
REQ-018 pop and push SHALL always assert in the same cycle; at most one bit each.
REQ-019 Exclusion rule (REQ-014) prevents double-popping a head not yet advanced; a sole active source is therefore served every second cycle.
REQ-020 almost_full asserting while a push to that destination is in flight does not cancel the in-flight push; it blocks only subsequent grants.
REQ-021 All four sources targeting the same destination: served one at a time in selection order, no word lost or duplicated.

Reset
REQ-022 While reset=0: state SETUP, pop=0, push=0, data_out=0, grant_id=0, idle=0, priority pointer=0.
REQ-023 Reset asserted mid-transfer clears outputs immediately (asynchronously); the in-flight pop/push is dropped.

Configuration
REQ-024 Macro ARB_RR_EN defined: round-robin selection; search starts at pointer, pointer becomes s+1 mod 4 after each grant.
REQ-025 ARB_RR_EN undefined: fixed priority, lowest eligible index wins; pointer logic absent; interface unchanged.

Structure
REQ-026 Package arbitro_pkg holds N_SRC=4, state encodings, and destination-field bit positions as functions of WIDTH.
REQ-027 Sub-module arb_pick: combinational 4-bit request vector plus 2-bit start pointer to one-hot grant and index; instantiated once.

Verification
REQ-028 Reset held 3 cycles then released, all empty -> one SETUP cycle, then idle=1, pop=push=0.
REQ-029 Source 2 non-empty only, head 6'b01_0101 -> pop=4'b0100, push=4'b0010, data_out=6'b010101 on alternating cycles.
REQ-030 ARB_RR_EN, all four non-empty, distinct destinations, no almost-full -> grant_id sequence 0,1,2,3,0 on consecutive cycles.
REQ-031 No ARB_RR_EN, same stimulus -> grant_id alternates 0,1,0,1 (source 0 excluded only after its own grant).
REQ-032 almost_fullFIFO raised 4'b1000 then 4'b1100 then 4'b1110 while all sources target destinations 3,2,1,0 -> grants to those sources stop one cycle after each flag; only destination-0 traffic remains.
REQ-033 reset pulsed low during push=4'b0001 -> push, pop, data_out read 0 before the next clk edge.
